// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-addressed data memory.
// Loads are combinational (sign/zero-extended), SW is a single write, and
// SB/SH become a read cycle followed by a merged whole-word write. Misaligned,
// malformed or out-of-range requests are blocked and reported as a fault.
module load_store_unit #(
  parameter int DEPTH_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        fault,
  output logic [31:0] fault_addr,
  output logic        dm_memread,
  output logic        dm_memwrite,
  output logic [31:0] dm_address,
  output logic [31:0] dm_write_data,
  input  logic [31:0] dm_rdata
);

  localparam logic [29:0] DEPTH_LIMIT = 30'(DEPTH_WORDS);

  typedef enum logic {
    IDLE,
    MERGE
  } state_t;

  state_t      state, state_nxt;
  logic        illegal;
  logic        fault_cond;
  logic        take_merge;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;
  logic [31:0] merged;
  logic [29:0] merge_idx;
  logic [31:0] merge_word;

  // Legality of the presented request: width encoding, store-only limits, alignment, range.
  always_comb begin
    illegal = 1'b0;
    case (funct3)
      3'b000:  illegal = 1'b0;
      3'b001:  illegal = addr[0];
      3'b010:  illegal = (addr[1:0] != 2'b00);
      3'b100:  illegal = mem_we;
      3'b101:  illegal = mem_we | addr[0];
      default: illegal = 1'b1;
    endcase
    if (addr[31:2] >= DEPTH_LIMIT) illegal = 1'b1;
  end

  // Lane selection and extension of the memory word for loads.
  always_comb begin
    case (addr[1:0])
      2'b00:   byte_sel = dm_rdata[7:0];
      2'b01:   byte_sel = dm_rdata[15:8];
      2'b10:   byte_sel = dm_rdata[23:16];
      default: byte_sel = dm_rdata[31:24];
    endcase
    half_sel = addr[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    case (funct3)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'h0, byte_sel};
      3'b101:  load_ext = {16'h0, half_sel};
      default: load_ext = dm_rdata;
    endcase
  end

  // Read word with the addressed byte or halfword replaced by store data.
  always_comb begin
    merged = dm_rdata;
    if (funct3[1:0] == 2'b00) merged[{addr[1:0], 3'b000} +: 8] = wdata[7:0];
    else                      merged[{addr[1], 4'b0000} +: 16] = wdata[15:0];
  end

  // Next-state and output decode; memory strobes are forced off during reset.
  always_comb begin
    state_nxt     = state;
    stall         = 1'b0;
    load_data     = 32'h0;
    dm_memread    = 1'b0;
    dm_memwrite   = 1'b0;
    dm_address    = 32'h0;
    dm_write_data = 32'h0;
    take_merge    = 1'b0;
    fault_cond    = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req && illegal) begin
          fault_cond = 1'b1;
        end else if (mem_req) begin
          dm_address = {addr[31:2], 2'b00};
          if (!mem_we) begin
            dm_memread = 1'b1;
            load_data  = load_ext;
          end else if (funct3 == 3'b010) begin
            dm_memwrite   = 1'b1;
            dm_write_data = wdata;
          end else begin
            dm_memread = 1'b1;
            stall      = 1'b1;
            take_merge = 1'b1;
            state_nxt  = MERGE;
          end
        end
      end
      MERGE: begin
        dm_memwrite   = 1'b1;
        dm_address    = {merge_idx, 2'b00};
        dm_write_data = merge_word;
        state_nxt     = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      dm_memread  = 1'b0;
      dm_memwrite = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Fault reporting and the latched read-modify-write word.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault      <= 1'b0;
      fault_addr <= 32'h0;
      merge_idx  <= 30'h0;
      merge_word <= 32'h0;
    end else begin
      fault <= fault_cond;
      if (fault_cond) fault_addr <= addr;
      if (take_merge) begin
        merge_idx  <= addr[31:2];
        merge_word <= merged;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model predicts every
// cycle's outputs, a single compare process checks them, and literal checks
// pin the headline load results and fault addresses.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic        mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        fault;
  logic [31:0] fault_addr;
  logic        dm_memread;
  logic        dm_memwrite;
  logic [31:0] dm_address;
  logic [31:0] dm_write_data;
  logic [31:0] dm_rdata;

  load_store_unit #(.DEPTH_WORDS(64)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .stall(stall), .load_data(load_data),
    .fault(fault), .fault_addr(fault_addr), .dm_memread(dm_memread),
    .dm_memwrite(dm_memwrite), .dm_address(dm_address),
    .dm_write_data(dm_write_data), .dm_rdata(dm_rdata)
  );

  always #5 clk = ~clk;

  // Data memory seen by the DUT.
  logic [31:0] tb_mem [64];
  logic        mem_clr;
  assign dm_rdata = tb_mem[dm_address[7:2]];
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= 32'h0;
    end else if (dm_memwrite) begin
      tb_mem[dm_address[7:2]] <= dm_write_data;
    end
  end

  // Reference model state and per-cycle expectations.
  logic [31:0] ref_mem [64];
  int          vectors = 0;
  int          miscompares = 0;
  bit          chk_en = 0;
  bit          rst_cyc;
  bit          chk_addr, chk_wdat;
  bit          pend;
  logic [31:0] pend_a;
  logic        e_rd, e_wr, e_stall, e_fault;
  logic [31:0] e_ld, e_addr, e_wdat, e_faddr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  function automatic int unsigned acc_size(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit model_legal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int unsigned sz = acc_size(f3);
    if (sz == 0) return 0;
    if (we && (f3 == 3'b100 || f3 == 3'b101)) return 0;
    if ((a % sz) != 0) return 0;
    if ((a / 4) >= 64) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [2:0] f3,
                                             input logic [31:0] a);
    logic [31:0] v = word >> (8 * (a % 4));
    logic [31:0] r;
    case (f3)
      3'b000: begin r = v & 32'hFF;   if (r >= 128)   r = r - 32'd256;   end
      3'b100:       r = v & 32'hFF;
      3'b001: begin r = v & 32'hFFFF; if (r >= 32768) r = r - 32'd65536; end
      3'b101:       r = v & 32'hFFFF;
      default:      r = word;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] model_merge(input logic [31:0] word, input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] wd);
    int unsigned sh = 8 * (a % 4);
    logic [31:0] mask = ((acc_size(f3) == 1) ? 32'hFF : 32'hFFFF) << sh;
    return (word & ~mask) | ((wd << sh) & mask);
  endfunction

  // Single compare process against the model's expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      check("dm_memread", 32'(dm_memread), 32'(e_rd));
      check("dm_memwrite", 32'(dm_memwrite), 32'(e_wr));
      if (!rst_cyc) begin
        check("stall", 32'(stall), 32'(e_stall));
        check("load_data", load_data, e_ld);
        check("fault", 32'(fault), 32'(e_fault));
        check("fault_addr", fault_addr, e_faddr);
        if (chk_addr) check("dm_address", dm_address, e_addr);
        if (chk_wdat) check("dm_write_data", dm_write_data, e_wdat);
      end
    end
  end

  task automatic begin_cycle();
    @(posedge clk);
    #1;
    e_fault = pend;
    if (pend) e_faddr = pend_a;
    pend = 0;
    e_rd = 0; e_wr = 0; e_stall = 0;
    e_ld = 0; e_addr = 0; e_wdat = 0;
    chk_addr = 1; chk_wdat = 1; rst_cyc = 0;
  endtask

  task automatic idle();
    begin_cycle();
    mem_req = 0;
  endtask

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit drop_req = 0);
    int idx;
    begin_cycle();
    mem_req = 1; mem_we = we; funct3 = f3; addr = a; wdata = wd;
    idx = int'(a / 4);
    if (!model_legal(we, f3, a)) begin
      pend = 1; pend_a = a;
      chk_addr = 0; chk_wdat = 0;
    end else if (!we) begin
      e_rd = 1; e_addr = a & 32'hFFFF_FFFC; chk_wdat = 0;
      e_ld = model_load(ref_mem[idx], f3, a);
    end else if (f3 == 3'b010) begin
      e_wr = 1; e_addr = a; e_wdat = wd;
      ref_mem[idx] = wd;
    end else begin
      e_rd = 1; e_stall = 1; e_addr = a & 32'hFFFF_FFFC; chk_wdat = 0;
      begin_cycle();
      if (drop_req) mem_req = 0;
      e_wr = 1; e_addr = a & 32'hFFFF_FFFC;
      e_wdat = model_merge(ref_mem[idx], f3, a, wd);
      ref_mem[idx] = e_wdat;
    end
  endtask

  task automatic load_lit(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] exp);
    access(1'b0, f3, a, 32'h0);
    @(negedge clk);
    #1;
    check(name, load_data, exp);
  endtask

  task automatic fault_lit(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] exp);
    access(we, f3, a, 32'h0);
    idle();
    @(negedge clk);
    #1;
    check("fault pulse", 32'(fault), 32'd1);
    check("fault_addr lit", fault_addr, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
    rst = 1; mem_clr = 1;
    mem_req = 0; mem_we = 0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    pend = 0; pend_a = 0; e_faddr = 0; e_fault = 0;
    repeat (2) @(posedge clk);
    #1 mem_clr = 0;
    begin_cycle();
    rst = 0;
    chk_en = 1;

    // SW then loads of every width.
    access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
    idle();
    load_lit("LW 0x10", 3'b010, 32'h10, 32'hDEADBEEF);
    load_lit("LB 0x13", 3'b000, 32'h13, 32'hFFFFFFDE);
    load_lit("LBU 0x13", 3'b100, 32'h13, 32'h000000DE);
    load_lit("LH 0x10", 3'b001, 32'h10, 32'hFFFFBEEF);
    load_lit("LHU 0x12", 3'b101, 32'h12, 32'h0000DEAD);
    idle();

    // SB read-modify-write.
    access(1'b1, 3'b000, 32'h11, 32'h55);
    idle();
    load_lit("LW after SB", 3'b010, 32'h10, 32'hDEAD55EF);
    idle();

    // Faulting requests.
    fault_lit(1'b0, 3'b010, 32'h12, 32'h12);
    fault_lit(1'b1, 3'b001, 32'h03, 32'h03);
    fault_lit(1'b0, 3'b010, 32'h100, 32'h100);
    fault_lit(1'b1, 3'b100, 32'h40, 32'h40);
    fault_lit(1'b0, 3'b011, 32'h44, 32'h44);
    idle();

    // Highest legal word, and an SH in the upper half.
    access(1'b1, 3'b010, 32'hFC, 32'h01234567);
    access(1'b1, 3'b001, 32'hFE, 32'h0000CAFE);
    idle();
    load_lit("LW 0xFC", 3'b010, 32'hFC, 32'hCAFE4567);
    idle();

    // Reset during the MERGE cycle drops the write.
    begin_cycle();
    mem_req = 1; mem_we = 1; funct3 = 3'b001; addr = 32'h20; wdata = 32'h1234;
    e_rd = 1; e_stall = 1; e_addr = 32'h20; chk_wdat = 0;
    begin_cycle();
    rst = 1; rst_cyc = 1;
    begin_cycle();
    rst = 0; mem_req = 0;
    e_fault = 0; e_faddr = 0;
    @(negedge clk);
    #1 check("fault_addr after reset", fault_addr, 32'h0);
    load_lit("LW 0x20 after dropped SH", 3'b010, 32'h20, 32'h0);
    idle();

    // Back-to-back SB, first with mem_req dropped during its MERGE cycle.
    access(1'b1, 3'b000, 32'h30, 32'hAA, 1'b1);
    access(1'b1, 3'b000, 32'h31, 32'hBB);
    idle();
    load_lit("LW 0x30", 3'b010, 32'h30, 32'h0000BBAA);
    idle();
    idle();

    @(posedge clk);
    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
